// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store controller:
// funct3 codes, FSM state encoding and request legality decode.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_WR,
        S_ERR,
        S_RESP
    } state_t;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends load data from a memory word,
// and merges a store byte/half into a previously read word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = lsu_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word[{off, 3'b000} +: 8];
    assign half_lane = word[{off[1], 4'b0000} +: 16];

    // funct3[2] marks the unsigned load variants.
    always_comb begin
        load_data = word;
        case (funct3[1:0])
            2'b00: load_data = {{(XLEN-8){byte_lane[7] & ~funct3[2]}}, byte_lane};
            2'b01: load_data = {{(XLEN-16){half_lane[15] & ~funct3[2]}}, half_lane};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3[1:0])
            2'b00: merged[{off, 3'b000} +: 8] = wdata[7:0];
            2'b01: merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer onto a word-addressed registered-read memory:
// single read for loads, single write for SW, read-modify-write for SB/SH.
module dmem_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN    = lsu_pkg::XLEN,
    parameter int WORD_AW = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output logic               resp_valid,
    output logic [XLEN-1:0]    resp_rdata,
    output logic               resp_err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [WORD_AW-1:0] mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_rdata
);

    state_t               state, state_nxt;
    logic                 r_we;
    logic [2:0]           r_f3;
    logic [WORD_AW+1:0]   r_addr;
    logic [XLEN-1:0]      r_wdata;
    logic [XLEN-1:0]      r_merge;
    logic [XLEN-1:0]      load_data;
    logic [XLEN-1:0]      merged;
    logic                 misal;
    logic                 oor;
    logic                 req_err;
    logic                 accept;

    always_comb begin
        misal = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misal = req_addr[0];
            2'b10:   misal = |req_addr[1:0];
            default: misal = 1'b0;
        endcase
    end

    assign oor     = |req_addr[XLEN-1:WORD_AW+2];
    assign req_err = !f3_legal(req_we, req_funct3) || misal || oor;
    assign accept  = req_valid && req_ready;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (r_f3),
        .off       (r_addr[1:0]),
        .word      (mem_rdata),
        .wdata     (r_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            r_we       <= 1'b0;
            r_f3       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_merge    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[WORD_AW+1:0];
                r_wdata <= req_wdata;
            end
            // Response registers only change on the way into RESP, so they
            // hold between responses.
            case (state)
                S_RWAIT: begin
                    r_merge <= merged;
                    if (!r_we) begin
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                    end
                end
                S_WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                S_ERR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_nxt = S_ERR;
                    else if (req_we && req_funct3 == F3_W)
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD: begin
                mem_en    = 1'b1;
                state_nxt = S_RWAIT;
            end
            S_RWAIT: state_nxt = r_we ? S_WR : S_RESP;
            S_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                state_nxt = S_RESP;
            end
            S_ERR: state_nxt = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Reset must suppress any in-flight write in the reset cycle itself.
        if (rst) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            mem_en     = 1'b0;
            mem_we     = 1'b0;
        end
    end

    assign mem_addr  = r_addr[WORD_AW+1:2];
    assign mem_wdata = (state == S_WR && !rst) ?
                       ((r_f3 == F3_W) ? r_wdata : r_merge) : '0;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed and random requests
// against a byte-arithmetic reference model of memory and responses.
module tb_dmem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_lsu_ctrl #(.XLEN(32), .WORD_AW(18)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int waited);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!req_ready && waited < 20);
        if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    // Reference model computes the expected outcome from the ISA rules,
    // then the observed cycle-by-cycle behaviour is compared against it.
    task automatic observe(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input string tag);
        int lat = 0, rd = 0, wr = 0, rdc = 0, wrc = 0;
        logic [31:0] wa = 0, wd = 0, rdat = 0;
        logic rerr = 0, bad_ready = 0;
        logic legal, e;
        int size, sh, elat, erdc, ewrc, idx;
        logic [31:0] w, v, er, ew, mask;

        legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e     = !legal || (addr % size != 0) || (addr >= 32'h0010_0000);
        idx   = (addr >> 2) & 255;
        w     = ref_mem[idx];
        sh    = (addr % 4) * 8;
        er = 0; ew = 0; elat = 0; erdc = 0; ewrc = 0;
        if (e) begin
            elat = 2;
        end else if (!we) begin
            elat = 3; erdc = 1;
            v = w >> sh;
            if (size == 1) begin
                er = v & 32'hFF;
                if (f3 == 0 && er >= 128) er = er - 256;
            end else if (size == 2) begin
                er = v & 32'hFFFF;
                if (f3 == 1 && er >= 32768) er = er - 65536;
            end else begin
                er = w;
            end
        end else if (size == 4) begin
            elat = 2; ewrc = 1; ew = wdata;
        end else begin
            elat = 4; erdc = 1; ewrc = 3;
            mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
            ew = (w & ~mask) | ((wdata << sh) & mask);
        end
        if (we && !e) ref_mem[idx] = ew;

        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (req_ready) bad_ready = 1'b1;
            if (mem_en) begin
                if (mem_we) begin wr++; wrc = n; wa = 32'(mem_addr); wd = mem_wdata; end
                else begin rd++; rdc = n; end
            end
            if (resp_valid) begin
                lat = n; rdat = resp_rdata; rerr = resp_err;
                break;
            end
        end

        check({tag, ".lat"}, lat, elat);
        check({tag, ".err"}, 32'(rerr), 32'(e));
        check({tag, ".rdata"}, rdat, er);
        check({tag, ".reads"}, rd, erdc ? 1 : 0);
        check({tag, ".rd_cyc"}, rdc, erdc);
        check({tag, ".writes"}, wr, ewrc ? 1 : 0);
        check({tag, ".wr_cyc"}, wrc, ewrc);
        check({tag, ".ready_busy"}, 32'(bad_ready), 32'd0);
        if (ewrc != 0) begin
            check({tag, ".wr_addr"}, wa, 32'(idx));
            check({tag, ".wr_data"}, wd, ew);
        end
        if (!e) check({tag, ".mem"}, mem[idx], ref_mem[idx]);
    endtask

    task automatic op(input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input string tag);
        int waited;
        present(we, f3, addr, wdata, waited);
        req_valid = 1'b0;
        observe(we, f3, addr, wdata, tag);
    endtask

    initial begin
        int waited, cnt;
        logic we;
        logic [2:0] f3;
        logic [31:0] addr, held;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'h8077_F0A5; ref_mem[5] = 32'h8077_F0A5;
        mem[2] = 32'h1122_3344; ref_mem[2] = 32'h1122_3344;
        mem_rdata = '0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;

        @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.err", 32'(resp_err), 32'd0);
        check("rst.mem_en", 32'(mem_en), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", 32'(mem_addr), 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.ready", 32'(req_ready), 32'd1);

        op(1'b0, 3'b000, 32'h15, 32'h0, "lb_15");
        check("lb_15.value", resp_rdata, 32'hFFFF_FFF0);
        @(negedge clk);
        check("resp.pulse", 32'(resp_valid), 32'd0);
        check("resp.hold", resp_rdata, 32'hFFFF_FFF0);
        check("resp.idle_ready", 32'(req_ready), 32'd1);
        op(1'b0, 3'b100, 32'h15, 32'h0, "lbu_15");
        check("lbu_15.value", resp_rdata, 32'h0000_00F0);
        op(1'b0, 3'b001, 32'h16, 32'h0, "lh_16");
        check("lh_16.value", resp_rdata, 32'hFFFF_8077);
        op(1'b0, 3'b010, 32'h14, 32'h0, "lw_14");
        check("lw_14.value", resp_rdata, 32'h8077_F0A5);

        op(1'b1, 3'b000, 32'h0A, 32'h0000_00AB, "sb_0a");
        check("sb_0a.word", mem[2], 32'h11AB_3344);
        op(1'b1, 3'b001, 32'h08, 32'h0000_BEEF, "sh_08");
        check("sh_08.word", mem[2], 32'h11AB_BEEF);
        op(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, "sw_40");
        check("sw_40.word", mem[16], 32'hDEAD_BEEF);

        op(1'b0, 3'b010, 32'h42, 32'h0, "lw_mis");
        op(1'b0, 3'b001, 32'h43, 32'h0, "lh_mis");
        op(1'b1, 3'b100, 32'h20, 32'h1234, "st_f3_100");
        op(1'b0, 3'b010, 32'h0100_0000, 32'h0, "lw_oor");
        check("err.flag", 32'(resp_err), 32'd1);

        // Reset lands in the WR cycle of an SB: no write, no response.
        held = mem[3];
        present(1'b1, 3'b000, 32'h0D, 32'h0000_0055, waited);
        req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_wr.mem_we", 32'(mem_we), 32'd0);
        check("rst_wr.mem_en", 32'(mem_en), 32'd0);
        check("rst_wr.resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr.ready_after", 32'(req_ready), 32'd1);
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            if (resp_valid) cnt++;
            @(negedge clk);
        end
        check("rst_wr.no_resp", cnt, 0);
        check("rst_wr.word", mem[3], held);

        // Valid held high across back-to-back LW then SW.
        present(1'b0, 3'b010, 32'h14, 32'h0, waited);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h44; req_wdata = 32'hCAFE_F00D;
        observe(1'b0, 3'b010, 32'h14, 32'h0, "b2b_lw");
        present(1'b1, 3'b010, 32'h44, 32'hCAFE_F00D, waited);
        check("b2b.accept_wait", waited, 1);
        req_valid = 1'b0;
        observe(1'b1, 3'b010, 32'h44, 32'hCAFE_F00D, "b2b_sw");

        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom % 2);
            f3   = 3'($urandom % 8);
            addr = $urandom % 1024;
            if ($urandom % 4 != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            if ($urandom % 8 == 0) addr = addr | 32'h0010_0000 | ($urandom & 32'hFFF0_0000);
            op(we, f3, addr, $urandom, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
